// File: rtl/regfile_be.sv
// regfile_be -- parametrised register file with per-lane byte enables.
//
// Purpose:
//   DEPTH x DATA_W register file with two combinational read ports, one
//   lane-enabled write port and one single-cycle increment/decrement port
//   for pointer registers. After every reset a clear sequencer zeroes one
//   entry per cycle. All access is gated until the clear completes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   ready      high once the clear sequence has finished
//   wr_en      write strobe
//   wr_addr    write address
//   wr_be      per-lane write enables (bit i -> bits [i*LANE_W +: LANE_W])
//   wr_data    write data
//   ra_addr    read port A address
//   ra_data    read port A data (combinational)
//   rb_addr    read port B address
//   rb_data    read port B data (combinational)
//   inc_en     increment/decrement strobe
//   inc_addr   increment/decrement target
//   inc_dec    0 = add inc_step, 1 = subtract inc_step
//   inc_step   unsigned step, zero-extended to DATA_W
//   inc_carry  carry (add) or borrow (sub) of the op on the previous edge
//   collide    inc op dropped because a write hit the same address
module regfile_be #(
  parameter int DATA_W  = 16,
  parameter int LANE_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       ready,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/LANE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          ra_addr,
  output logic [DATA_W-1:0]          ra_data,
  input  logic [ADDR_W-1:0]          rb_addr,
  output logic [DATA_W-1:0]          rb_data,
  input  logic                       inc_en,
  input  logic [ADDR_W-1:0]          inc_addr,
  input  logic                       inc_dec,
  input  logic [LANE_W-1:0]          inc_step,
  output logic                       inc_carry,
  output logic                       collide
);

  localparam int LANES = DATA_W / LANE_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   clr_cnt_reg;
  logic [DATA_W-1:0]   mem_reg [DEPTH];

  // An address names a real register only if it is below DEPTH and, when
  // register 0 is hardwired, it is not 0.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !(ZERO_R0 && (a == '0));
  endfunction

  logic is_ready;
  logic wr_ok;
  logic inc_ok;
  logic collide_now;

  assign is_ready    = (state_reg == READY);
  // Reset dominates: no storage update on an edge where rst_n is low.
  assign wr_ok       = rst_n && is_ready && wr_en && addr_ok(wr_addr);
  assign collide_now = rst_n && is_ready && wr_en && inc_en &&
                       (wr_addr == inc_addr) && addr_ok(inc_addr);
  assign inc_ok      = rst_n && is_ready && inc_en && addr_ok(inc_addr) &&
                       !collide_now;

  // Word selection for both read ports and the inc operand.
  logic [DATA_W-1:0] ra_word;
  logic [DATA_W-1:0] rb_word;
  logic [DATA_W-1:0] inc_word;

  always_comb begin
    ra_word  = '0;
    rb_word  = '0;
    inc_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra_addr == ADDR_W'(i))  ra_word  = mem_reg[i];
      if (rb_addr == ADDR_W'(i))  rb_word  = mem_reg[i];
      if (inc_addr == ADDR_W'(i)) inc_word = mem_reg[i];
    end
  end

  assign ra_data = (is_ready && addr_ok(ra_addr)) ? ra_word : '0;
  assign rb_data = (is_ready && addr_ok(rb_addr)) ? rb_word : '0;

  // One extra bit holds the carry on add; on subtract the same bit is the
  // borrow, which is set exactly when step > reg.
  logic [DATA_W:0] step_ext;
  logic [DATA_W:0] inc_res;

  assign step_ext = {{(DATA_W + 1 - LANE_W){1'b0}}, inc_step};
  assign inc_res  = inc_dec ? ({1'b0, inc_word} - step_ext)
                            : ({1'b0, inc_word} + step_ext);

  // Lane-merged write value: enabled lanes from wr_data, others held.
  logic [DATA_W-1:0] wr_word;

  always_comb begin
    wr_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_word = mem_reg[i];
    end
    for (int l = 0; l < LANES; l++) begin
      if (wr_be[l]) wr_word[l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
    end
  end

  // Storage is not reset directly; the clear sequencer zeroes it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic clr_hit;
    logic wr_hit;
    logic inc_hit;

    assign clr_hit = rst_n && !is_ready && (clr_cnt_reg == ADDR_W'(gi));
    assign wr_hit  = wr_ok  && (wr_addr  == ADDR_W'(gi));
    assign inc_hit = inc_ok && (inc_addr == ADDR_W'(gi));

    always_ff @(posedge clk) begin
      if (clr_hit) begin
        mem_reg[gi] <= '0;
      end else if (wr_hit) begin
        mem_reg[gi] <= wr_word;
      end else if (inc_hit) begin
        mem_reg[gi] <= inc_res[DATA_W-1:0];
      end
    end
  end

  // Clear sequencer and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      ready       <= 1'b0;
      inc_carry   <= 1'b0;
      collide     <= 1'b0;
    end else begin
      inc_carry <= inc_ok && inc_res[DATA_W];
      collide   <= collide_now;
      case (state_reg)
        CLEAR: begin
          if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg   <= READY;
            ready       <= 1'b1;
            clr_cnt_reg <= '0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        READY: begin
          ready <= 1'b1;
        end
        default: begin
          state_reg <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_be.sv
module tb_regfile_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default parameters
  logic        rst_n, ready, wr_en, inc_en, inc_dec, inc_carry, collide;
  logic [3:0]  wr_addr, ra_addr, rb_addr, inc_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data, ra_data, rb_data;
  logic [7:0]  inc_step;

  regfile_be dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(rb_addr), .rb_data(rb_data),
    .inc_en(inc_en), .inc_addr(inc_addr), .inc_dec(inc_dec), .inc_step(inc_step),
    .inc_carry(inc_carry), .collide(collide)
  );

  // Second instance: hardwired r0, 5-bit addresses over 16 entries
  logic        z_rst_n, z_ready, z_wr_en, z_inc_en, z_inc_dec, z_inc_carry, z_collide;
  logic [4:0]  z_wr_addr, z_ra_addr, z_rb_addr, z_inc_addr;
  logic [1:0]  z_wr_be;
  logic [15:0] z_wr_data, z_ra_data, z_rb_data;
  logic [7:0]  z_inc_step;

  regfile_be #(.DATA_W(16), .LANE_W(8), .DEPTH(16), .ADDR_W(5), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst_n(z_rst_n), .ready(z_ready),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_be(z_wr_be), .wr_data(z_wr_data),
    .ra_addr(z_ra_addr), .ra_data(z_ra_data), .rb_addr(z_rb_addr), .rb_data(z_rb_data),
    .inc_en(z_inc_en), .inc_addr(z_inc_addr), .inc_dec(z_inc_dec), .inc_step(z_inc_step),
    .inc_carry(z_inc_carry), .collide(z_collide)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit        rst_n;
    bit        wr_en;
    bit [3:0]  wa;
    bit [1:0]  be;
    bit [15:0] wd;
    bit        inc_en;
    bit [3:0]  ia;
    bit        dec;
    bit [7:0]  step;
    bit [3:0]  ra;
    bit [3:0]  rb;
  } stim_t;

  typedef struct {
    string     tag;
    bit        ready;
    bit        carry;
    bit        collide;
    bit [15:0] ra;
    bit [15:0] rb;
  } exp_t;

  exp_t sb[$];

  // Reference model: plain integers, reset zeroes everything and access opens
  // after 16 released edges.
  int unsigned m_mem[16];
  bit          m_ready;
  int          m_clear_left;
  bit          m_carry;
  bit          m_collide;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_ready = 0;
    m_clear_left = 16;
    m_carry = 0;
    m_collide = 0;
  endtask

  task automatic model_edge(input stim_t s);
    int unsigned v;
    if (!s.rst_n) begin
      model_reset();
      return;
    end
    if (!m_ready) begin
      m_carry = 0;
      m_collide = 0;
      m_clear_left--;
      if (m_clear_left == 0) m_ready = 1;
      return;
    end
    m_collide = s.wr_en && s.inc_en && (s.wa == s.ia);
    m_carry = 0;
    if (s.inc_en && !m_collide) begin
      v = m_mem[s.ia];
      if (s.dec) begin
        m_carry = (s.step > v);
        m_mem[s.ia] = (v - s.step) % 65536;
      end else begin
        m_carry = (v + s.step) > 65535;
        m_mem[s.ia] = (v + s.step) % 65536;
      end
    end
    if (s.wr_en) begin
      v = m_mem[s.wa];
      if (s.be[0]) v = (v & 32'hFF00) | (s.wd & 32'h00FF);
      if (s.be[1]) v = (v & 32'h00FF) | (s.wd & 32'hFF00);
      m_mem[s.wa] = v;
    end
  endtask

  function automatic stim_t idle(input bit [3:0] ra, input bit [3:0] rb);
    stim_t s;
    s = '{rst_n: 1'b1, wr_en: 1'b0, wa: 4'h0, be: 2'b00, wd: 16'h0,
          inc_en: 1'b0, ia: 4'h0, dec: 1'b0, step: 8'h0, ra: ra, rb: rb};
    return s;
  endfunction

  // Drive one cycle (called just after a rising edge), queue expectation.
  task automatic cycle(input stim_t s, input string tag);
    exp_t e;
    rst_n = s.rst_n;   wr_en = s.wr_en;   wr_addr = s.wa;   wr_be = s.be;
    wr_data = s.wd;    inc_en = s.inc_en; inc_addr = s.ia;  inc_dec = s.dec;
    inc_step = s.step; ra_addr = s.ra;    rb_addr = s.rb;
    e.tag = tag;
    e.ready = m_ready;
    e.carry = m_carry;
    e.collide = m_collide;
    e.ra = m_ready ? 16'(m_mem[s.ra]) : 16'h0;
    e.rb = m_ready ? 16'(m_mem[s.rb]) : 16'h0;
    sb.push_back(e);
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  task automatic do_wr(input bit [3:0] a, input bit [1:0] be, input bit [15:0] d, input string tag);
    stim_t s;
    s = idle(a, a);
    s.wr_en = 1; s.wa = a; s.be = be; s.wd = d;
    cycle(s, tag);
  endtask

  task automatic do_inc(input bit [3:0] a, input bit dec, input bit [7:0] step, input string tag);
    stim_t s;
    s = idle(a, a);
    s.inc_en = 1; s.ia = a; s.dec = dec; s.step = step;
    cycle(s, tag);
  endtask

  // Direct read of port A between cycles (does not advance the clock).
  task automatic peek(input string name, input logic [3:0] a, input logic [15:0] exp);
    ra_addr = a;
    #1;
    check(name, ra_data, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("txn %s ready=%0b carry=%0b collide=%0b ra=%h rb=%h",
               e.tag, ready, inc_carry, collide, ra_data, rb_data);
      check({e.tag, ".ready"},   ready,     e.ready);
      check({e.tag, ".carry"},   inc_carry, e.carry);
      check({e.tag, ".collide"}, collide,   e.collide);
      check({e.tag, ".ra"},      ra_data,   e.ra);
      check({e.tag, ".rb"},      rb_data,   e.rb);
    end
  end

  task automatic zcyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst_n = 0; wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; inc_en = 0;
    inc_addr = 0; inc_dec = 0; inc_step = 0; ra_addr = 0; rb_addr = 0;
    z_rst_n = 0; z_wr_en = 0; z_wr_addr = 0; z_wr_be = 0; z_wr_data = 0; z_inc_en = 0;
    z_inc_addr = 0; z_inc_dec = 0; z_inc_step = 0; z_ra_addr = 0; z_rb_addr = 0;

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset.ready", ready, 0);
    check("reset.carry", inc_carry, 0);
    check("reset.collide", collide, 0);

    // Clear with an ignored write to addr 3
    for (int i = 0; i < 16; i++) begin
      s = idle(4'(i), 4'd3);
      s.wr_en = 1; s.wa = 4'd3; s.be = 2'b11; s.wd = 16'hBEEF;
      cycle(s, "clear");
      check("clear.ready_edge", ready, (i == 15) ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(idle(4'(i), 4'(15 - i)), "postclear");
      peek("postclear.zero", 4'(i), 16'h0000);
    end

    // Lane writes
    do_wr(4'd5, 2'b10, 16'h12AB, "be_hi");
    do_wr(4'd5, 2'b01, 16'hCD34, "be_lo");
    peek("lane.merge", 4'd5, 16'h1234);
    do_wr(4'd5, 2'b00, 16'hFFFF, "be_none");
    peek("lane.none", 4'd5, 16'h1234);

    // Inc/dec with carry and borrow
    do_wr(4'd7, 2'b11, 16'hFFFE, "r7_init");
    do_inc(4'd7, 0, 8'd3, "inc3");
    check("inc3.carry", inc_carry, 1);
    peek("inc3.val", 4'd7, 16'h0001);
    do_inc(4'd7, 1, 8'd2, "dec2");
    check("dec2.borrow", inc_carry, 1);
    peek("dec2.val", 4'd7, 16'hFFFF);
    do_inc(4'd7, 1, 8'd1, "dec1");
    check("dec1.borrow", inc_carry, 0);
    peek("dec1.val", 4'd7, 16'hFFFE);

    // Collisions
    do_wr(4'd4, 2'b11, 16'h0009, "r4_init");
    s = idle(4'd2, 4'd4);
    s.wr_en = 1; s.wa = 4'd2; s.be = 2'b11; s.wd = 16'h5555;
    s.inc_en = 1; s.ia = 4'd2; s.step = 8'd1;
    cycle(s, "same_addr");
    check("same.collide", collide, 1);
    check("same.carry", inc_carry, 0);
    peek("same.val", 4'd2, 16'h5555);
    s = idle(4'd2, 4'd4);
    s.wr_en = 1; s.wa = 4'd2; s.be = 2'b11; s.wd = 16'h6666;
    s.inc_en = 1; s.ia = 4'd4; s.step = 8'd1;
    cycle(s, "diff_addr");
    check("diff.collide", collide, 0);
    peek("diff.r2", 4'd2, 16'h6666);
    peek("diff.r4", 4'd4, 16'h000A);

    // Reset mid-clear, then count to ready
    s = idle(4'd0, 4'd1); s.rst_n = 0;
    cycle(s, "rst1");
    for (int i = 0; i < 8; i++) cycle(idle(4'd0, 4'd1), "clear8");
    cycle(s, "rst2");
    for (int i = 0; i < 16; i++) begin
      cycle(idle(4'(i), 4'd5), "reclear");
      check("reclear.ready_edge", ready, (i == 15) ? 1 : 0);
    end

    // Reset in READY with data loaded
    do_wr(4'd9, 2'b11, 16'hA5A5, "load9");
    do_wr(4'd15, 2'b11, 16'h0F0F, "load15");
    cycle(s, "rst_ready");
    for (int i = 0; i < 16; i++) cycle(idle(4'd9, 4'd15), "clear_again");
    for (int i = 0; i < 16; i++) begin
      cycle(idle(4'(i), 4'(i ^ 5)), "zero_again");
      peek("zero_again.val", 4'(i), 16'h0000);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = idle(4'($urandom), 4'($urandom));
      s.rst_n = ($urandom_range(0, 149) != 0);
      s.wr_en = $urandom_range(0, 1);
      s.wa = 4'($urandom);
      s.be = 2'($urandom);
      s.wd = 16'($urandom);
      s.inc_en = $urandom_range(0, 1);
      s.ia = ($urandom_range(0, 3) == 0) ? s.wa : 4'($urandom);
      s.dec = $urandom_range(0, 1);
      s.step = 8'($urandom);
      cycle(s, "rand");
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end

    // ZERO_R0 / out-of-range instance
    z_rst_n = 0;
    zcyc();
    zcyc();
    z_rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      zcyc();
      check("z.clear_ready", z_ready, (i == 15) ? 1 : 0);
    end
    z_wr_en = 1; z_wr_addr = 5'd0; z_wr_be = 2'b11; z_wr_data = 16'hAAAA;
    zcyc();
    z_wr_en = 0;
    z_inc_en = 1; z_inc_addr = 5'd0; z_inc_dec = 0; z_inc_step = 8'd1;
    zcyc();
    z_inc_en = 0;
    z_ra_addr = 5'd0;
    #1;
    check("z.r0_read", z_ra_data, 16'h0000);
    check("z.r0_carry", z_inc_carry, 0);
    check("z.r0_collide", z_collide, 0);
    z_wr_en = 1; z_wr_addr = 5'd1; z_wr_be = 2'b11; z_wr_data = 16'h1234;
    zcyc();
    z_wr_addr = 5'h10; z_wr_data = 16'h5A5A;
    zcyc();
    z_wr_en = 0;
    z_inc_en = 1; z_inc_addr = 5'h10; z_inc_step = 8'hFF;
    zcyc();
    z_inc_en = 0;
    check("z.oor_carry", z_inc_carry, 0);
    z_ra_addr = 5'h10; z_rb_addr = 5'h1F;
    #1;
    check("z.oor_read_a", z_ra_data, 16'h0000);
    check("z.oor_read_b", z_rb_data, 16'h0000);
    for (int a = 0; a < 16; a++) begin
      z_ra_addr = 5'(a);
      #1;
      check("z.entry", z_ra_data, (a == 1) ? 16'h1234 : 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
